data_mem_responder: RTL and testbench

//   MEM-stage data memory responder; consumer end of the EX/MEM register's memory request.

---
 rtl/data_mem_responder_if.sv | 34 +++
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the EX/MEM register and the data memory responder.
// err_o exists only when DMEM_ALIGN_CHECK_EN is defined.
interface data_mem_responder_if;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        ack_o;
   logic        stall_o;
`ifdef DMEM_ALIGN_CHECK_EN
   logic        err_o;
`endif

`ifdef DMEM_ALIGN_CHECK_EN
   modport slave (
      input  MemRead_i, MemWrite_i, addr_i, wdata_i,
      output rdata_o, ack_o, stall_o, err_o
   );
   modport master (
      output MemRead_i, MemWrite_i, addr_i, wdata_i,
      input  rdata_o, ack_o, stall_o, err_o
   );
`else
   modport slave (
      input  MemRead_i, MemWrite_i, addr_i, wdata_i,
      output rdata_o, ack_o, stall_o
   );
   modport master (
      output MemRead_i, MemWrite_i, addr_i, wdata_i,
      input  rdata_o, ack_o, stall_o
   );
`endif
endinterface

// File: rtl/data_mem_responder.sv
// MEM-stage data memory with fixed access latency and a pipeline stall request.
// Optional misalignment detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 3
) (
   input logic                 clk_i,
   input logic                 rst_i,
   data_mem_responder_if.slave bus
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             store_q, store_d;
   logic             fault_q, fault_d;

   logic [31:0]      mem [DEPTH_WORDS];

   logic             req;
   logic             req_fault;
   logic             stall;
   logic             access;
   logic             acc_store;
   logic             acc_fault;
   logic [IDX_W-1:0] acc_idx;
   logic [31:0]      acc_wdata;
   logic             mem_we;

   assign req = bus.MemRead_i | bus.MemWrite_i;

`ifdef DMEM_ALIGN_CHECK_EN
   assign req_fault = |bus.addr_i[1:0];
`else
   assign req_fault = 1'b0;
`endif

   // access marks the edge at which the array is touched; with LATENCY==1 that is
   // the accepting edge itself, so the live inputs are used instead of the latches
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      store_d   = store_q;
      fault_d   = fault_q;
      stall     = 1'b0;
      access    = 1'b0;
      acc_idx   = addr_q;
      acc_wdata = wdata_q;
      acc_store = store_q;
      acc_fault = fault_q;

      case (state_q)
         IDLE: begin
            if (req) begin
               stall   = 1'b1;
               addr_d  = bus.addr_i[IDX_W+1:2];
               wdata_d = bus.wdata_i;
               store_d = bus.MemWrite_i;
               fault_d = req_fault;
               cnt_d   = CNT_INIT;
               if (LATENCY == 1) begin
                  state_d   = RESP;
                  access    = 1'b1;
                  acc_idx   = bus.addr_i[IDX_W+1:2];
                  acc_wdata = bus.wdata_i;
                  acc_store = bus.MemWrite_i;
                  acc_fault = req_fault;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_d == 4'd0) begin
               state_d = RESP;
               access  = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (access && !acc_store && !acc_fault) begin
         rdata_d = mem[acc_idx];
      end
   end

   // Qualified by rst_i so an access caught by reset never commits
   assign mem_we = access && acc_store && !acc_fault && rst_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         store_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         store_q <= store_d;
         fault_q <= fault_d;
      end
   end

   // The array is deliberately left out of reset
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   assign bus.rdata_o = rdata_q;
   assign bus.ack_o   = (state_q == RESP);
   assign bus.stall_o = stall & rst_i;
`ifdef DMEM_ALIGN_CHECK_EN
   assign bus.err_o   = (state_q == RESP) & fault_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=3 main instance,
// LATENCY=1 secondary instance); alignment checks follow DMEM_ALIGN_CHECK_EN.
module tb_data_mem_responder;

   logic clk;
   logic rst_i;
   int   n_checks;
   int   n_fail;

   data_mem_responder_if bus0 ();
   data_mem_responder_if bus1 ();

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus0)
   );

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one request on bus0 and reports stall length, ack cycle and response;
   // ack_cycle stays -1 if no ack arrives within the cycle budget
   task automatic run_access(input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic alt_en, input logic [31:0] alt_addr,
                             output int stall_cycles, output int ack_cycle,
                             output logic [31:0] rdata_seen, output logic err_seen);
      stall_cycles = 0;
      ack_cycle    = -1;
      rdata_seen   = '0;
      err_seen     = 1'b0;
      bus0.MemRead_i  = rd;
      bus0.MemWrite_i = wr;
      bus0.addr_i     = addr;
      bus0.wdata_i    = wdata;
      #1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (alt_en && cyc == 1) bus0.addr_i = alt_addr;
         if (bus0.ack_o === 1'b1) begin
            ack_cycle  = cyc;
            rdata_seen = bus0.rdata_o;
`ifdef DMEM_ALIGN_CHECK_EN
            err_seen   = bus0.err_o;
`endif
            break;
         end
         if (bus0.stall_o === 1'b1) stall_cycles++;
         step();
      end
      bus0.MemRead_i  = 1'b0;
      bus0.MemWrite_i = 1'b0;
      step();
   endtask

   task automatic test_reset();
      bus0.MemRead_i  = 1'b1;
      bus0.MemWrite_i = 1'b0;
      bus0.addr_i     = 32'h0;
      bus0.wdata_i    = 32'h0;
      rst_i = 1'b1;
      #2 rst_i = 1'b0;
      #1;
      n_checks++;
      if (bus0.stall_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_stall: got %b expected 0", bus0.stall_o);
      end
      n_checks++;
      if (bus0.ack_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_ack: got %b expected 0", bus0.ack_o);
      end
      n_checks++;
      if (bus0.rdata_o !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_rdata: got %h expected 00000000", bus0.rdata_o);
      end
      bus0.MemRead_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_i = 1'b1;
      step();
   endtask

   task automatic test_store_load();
      int sc, ac;
      logic [31:0] rd;
      logic er;
      run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, sc, ac, rd, er);
      n_checks++;
      if (sc != 3) begin
         n_fail++;
         $display("[TB] FAIL sw_stall_cycles: got %0d expected 3", sc);
      end
      n_checks++;
      if (ac != 3) begin
         n_fail++;
         $display("[TB] FAIL sw_ack_cycle: got %0d expected 3", ac);
      end
      n_checks++;
      if (rd !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL sw_rdata_unchanged: got %h expected 00000000", rd);
      end
      n_checks++;
      if (bus0.ack_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL sw_ack_one_cycle: got %b expected 0", bus0.ack_o);
      end
      run_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, sc, ac, rd, er);
      n_checks++;
      if (ac != 3) begin
         n_fail++;
         $display("[TB] FAIL lw_ack_cycle: got %0d expected 3", ac);
      end
      n_checks++;
      if (sc != 3) begin
         n_fail++;
         $display("[TB] FAIL lw_stall_cycles: got %0d expected 3", sc);
      end
      n_checks++;
      if (rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("[TB] FAIL lw_rdata: got %h expected deadbeef", rd);
      end
      n_checks++;
      if (er !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL lw_aligned_err: got %b expected 0", er);
      end
   endtask

   task automatic test_wrap();
      int sc, ac;
      logic [31:0] rd;
      logic er;
      run_access(1'b0, 1'b1, 32'h400, 32'h1234, 1'b0, 32'h0, sc, ac, rd, er);
      run_access(1'b1, 1'b0, 32'h000, 32'h0, 1'b0, 32'h0, sc, ac, rd, er);
      n_checks++;
      if (rd !== 32'h1234 || ac != 3) begin
         n_fail++;
         $display("[TB] FAIL wrap_lw: got %h ack@%0d expected 00001234 ack@3", rd, ac);
      end
   endtask

   task automatic test_wait_change();
      int sc, ac;
      logic [31:0] rd;
      logic er;
      run_access(1'b0, 1'b1, 32'h20, 32'h2020, 1'b0, 32'h0, sc, ac, rd, er);
      run_access(1'b0, 1'b1, 32'h10, 32'h1111, 1'b1, 32'h20, sc, ac, rd, er);
      run_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, sc, ac, rd, er);
      n_checks++;
      if (rd !== 32'h1111) begin
         n_fail++;
         $display("[TB] FAIL wait_change_latched: got %h expected 00001111", rd);
      end
      run_access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, sc, ac, rd, er);
      n_checks++;
      if (rd !== 32'h2020) begin
         n_fail++;
         $display("[TB] FAIL wait_change_other: got %h expected 00002020", rd);
      end
   endtask

   task automatic test_both_set();
      int sc, ac;
      logic [31:0] rd;
      logic er;
      run_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, sc, ac, rd, er);
      run_access(1'b1, 1'b1, 32'h30, 32'h00C0FFEE, 1'b0, 32'h0, sc, ac, rd, er);
      n_checks++;
      if (rd !== 32'h1111 || ac != 3) begin
         n_fail++;
         $display("[TB] FAIL both_rdata_unchanged: got %h ack@%0d expected 00001111 ack@3", rd, ac);
      end
      run_access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0, sc, ac, rd, er);
      n_checks++;
      if (rd !== 32'h00C0FFEE) begin
         n_fail++;
         $display("[TB] FAIL both_is_store: got %h expected 00c0ffee", rd);
      end
   endtask

   task automatic test_reset_mid_resp();
      bus0.MemRead_i = 1'b1;
      bus0.addr_i    = 32'h30;
      step();
      step();
      step();
      n_checks++;
      if (bus0.ack_o !== 1'b1 || bus0.rdata_o !== 32'h00C0FFEE) begin
         n_fail++;
         $display("[TB] FAIL resp_before_reset: got ack=%b %h expected ack=1 00c0ffee",
                  bus0.ack_o, bus0.rdata_o);
      end
      #2 rst_i = 1'b0;
      #1;
      n_checks++;
      if (bus0.ack_o !== 1'b0 || bus0.rdata_o !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL async_reset_resp: got ack=%b %h expected ack=0 00000000",
                  bus0.ack_o, bus0.rdata_o);
      end
      bus0.MemRead_i = 1'b0;
      @(negedge clk);
      rst_i = 1'b1;
      step();
   endtask

   task automatic test_reset_abort();
      int sc, ac;
      logic [31:0] rd;
      logic er;
      logic seen_ack;
      run_access(1'b0, 1'b1, 32'h8, 32'h77, 1'b0, 32'h0, sc, ac, rd, er);
      bus0.MemWrite_i = 1'b1;
      bus0.addr_i     = 32'h8;
      bus0.wdata_i    = 32'h55;
      step();
      #2 rst_i = 1'b0;
      #1;
      n_checks++;
      if (bus0.stall_o !== 1'b0 || bus0.ack_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL abort_outputs: got stall=%b ack=%b expected 0 0",
                  bus0.stall_o, bus0.ack_o);
      end
      seen_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus0.ack_o !== 1'b0) seen_ack = 1'b1;
      end
      bus0.MemWrite_i = 1'b0;
      @(negedge clk);
      rst_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus0.ack_o !== 1'b0) seen_ack = 1'b1;
      end
      n_checks++;
      if (seen_ack !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL abort_no_ack: got %b expected 0", seen_ack);
      end
      run_access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, sc, ac, rd, er);
      n_checks++;
      if (rd !== 32'h77) begin
         n_fail++;
         $display("[TB] FAIL abort_not_committed: got %h expected 00000077", rd);
      end
   endtask

   task automatic test_alignment();
      int sc, ac;
      logic [31:0] rd;
      logic er;
      run_access(1'b0, 1'b1, 32'h13, 32'hABCD, 1'b0, 32'h0, sc, ac, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
      n_checks++;
      if (er !== 1'b1 || ac != 3) begin
         n_fail++;
         $display("[TB] FAIL misaligned_sw_err: got err=%b ack@%0d expected err=1 ack@3", er, ac);
      end
      n_checks++;
      if (bus0.err_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL err_after_resp: got %b expected 0", bus0.err_o);
      end
      run_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, sc, ac, rd, er);
      n_checks++;
      if (rd !== 32'h1111) begin
         n_fail++;
         $display("[TB] FAIL misaligned_sw_no_write: got %h expected 00001111", rd);
      end
      run_access(1'b1, 1'b0, 32'h31, 32'h0, 1'b0, 32'h0, sc, ac, rd, er);
      n_checks++;
      if (rd !== 32'h1111 || er !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL misaligned_lw: got %h err=%b expected 00001111 err=1", rd, er);
      end
`else
      run_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, sc, ac, rd, er);
      n_checks++;
      if (rd !== 32'hABCD) begin
         n_fail++;
         $display("[TB] FAIL low_bits_ignored: got %h expected 0000abcd", rd);
      end
`endif
   endtask

   task automatic test_back_to_back();
      bus1.MemWrite_i = 1'b1;
      bus1.addr_i     = 32'h44;
      bus1.wdata_i    = 32'h0BADF00D;
      #1;
      n_checks++;
      if (bus1.stall_o !== 1'b1 || bus1.ack_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL lat1_sw_accept: got stall=%b ack=%b expected 1 0",
                  bus1.stall_o, bus1.ack_o);
      end
      step();
      n_checks++;
      if (bus1.ack_o !== 1'b1 || bus1.stall_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL lat1_sw_ack: got ack=%b stall=%b expected 1 0",
                  bus1.ack_o, bus1.stall_o);
      end
      bus1.MemWrite_i = 1'b0;
      bus1.MemRead_i  = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (bus1.ack_o !== 1'(i % 2) || bus1.stall_o !== 1'((i + 1) % 2)) begin
            n_fail++;
            $display("[TB] FAIL lat1_b2b_cycle%0d: got ack=%b stall=%b expected ack=%0d stall=%0d",
                     i, bus1.ack_o, bus1.stall_o, i % 2, (i + 1) % 2);
         end
         if (i % 2 == 1) begin
            n_checks++;
            if (bus1.rdata_o !== 32'h0BADF00D) begin
               n_fail++;
               $display("[TB] FAIL lat1_b2b_rdata%0d: got %h expected 0badf00d", i, bus1.rdata_o);
            end
         end
         step();
      end
      bus1.MemRead_i = 1'b0;
      step();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      bus1.MemRead_i  = 1'b0;
      bus1.MemWrite_i = 1'b0;
      bus1.addr_i     = 32'h0;
      bus1.wdata_i    = 32'h0;
      test_reset();
      test_store_load();
      test_wrap();
      test_wait_change();
      test_both_set();
      test_reset_mid_resp();
      test_reset_abort();
      test_alignment();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
